// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes, memory pins and status for the memory port arbiter.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_ack;
   logic [DW-1:0] i_rdata;
   logic          i_err;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ack;
   logic [DW-1:0] d_rdata;
   logic          d_err;
   logic [AW-1:0] mem_a;
   logic          mem_we;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;
   logic          busy;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
      output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, mem_a, mem_we, mem_wd, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
      input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, mem_a, mem_we, mem_wd, busy
   );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time wins.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic [1:0] mask,
   output logic [1:0] gnt
);
   logic [1:0] elig;

   assign elig = req & ~mask;

   always_comb begin
      gnt = elig;
      if (elig == 2'b11)
         gnt = (last == PORT_D) ? 2'b01 : 2'b10;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between the fetch and data requesters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);
   state_t        state;
   logic          sel;
   logic          last_grant;
   logic          lat_we;
   logic [1:0]    mask;
   logic [1:0]    gnt;
   logic          win;
   logic          mis;
   logic [AW-1:0] win_addr;

   // The port just acked still holds req high, so keep it out of the RESP pick.
   assign mask = (state != RESP) ? 2'b00 : ((sel == PORT_D) ? 2'b10 : 2'b01);

   rr_arb2 u_arb (
      .req  ({bus.d_req, bus.i_req}),
      .last (last_grant),
      .mask (mask),
      .gnt  (gnt)
   );

   assign win      = gnt[1];
   assign win_addr = win ? bus.d_addr : bus.i_addr;
   assign mis      = |win_addr[1:0];
   assign bus.busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sel         <= PORT_I;
         last_grant  <= PORT_D;
         lat_we      <= 1'b0;
         bus.mem_a   <= '0;
         bus.mem_we  <= 1'b0;
         bus.mem_wd  <= '0;
         bus.i_ack   <= 1'b0;
         bus.i_err   <= 1'b0;
         bus.i_rdata <= '0;
         bus.d_ack   <= 1'b0;
         bus.d_err   <= 1'b0;
         bus.d_rdata <= '0;
      end else begin
         bus.i_ack  <= 1'b0;
         bus.d_ack  <= 1'b0;
         bus.i_err  <= 1'b0;
         bus.d_err  <= 1'b0;
         bus.mem_we <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (state == RESP)
                  last_grant <= sel;
               if (|gnt) begin
                  // mem_a/mem_wd double as the latched address/write data.
                  sel        <= win;
                  bus.mem_a  <= win_addr;
                  bus.mem_wd <= win ? bus.d_wdata : '0;
                  lat_we     <= win & bus.d_we;
                  if (mis) begin
                     state <= RESP;
                     if (win == PORT_D) begin
                        bus.d_ack   <= 1'b1;
                        bus.d_err   <= 1'b1;
                        bus.d_rdata <= '0;
                     end else begin
                        bus.i_ack   <= 1'b1;
                        bus.i_err   <= 1'b1;
                        bus.i_rdata <= '0;
                     end
                  end else begin
                     state      <= ACCESS;
                     bus.mem_we <= win & bus.d_we;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               state <= RESP;
               if (sel == PORT_D) begin
                  bus.d_ack   <= 1'b1;
                  bus.d_rdata <= lat_we ? '0 : bus.mem_rd;
               end else begin
                  bus.i_ack   <= 1'b1;
                  bus.i_rdata <= bus.mem_rd;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
